// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage ALU: single-cycle logic/arith ops, iterative 1-bit/cycle shifts.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter int ALU_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ALU_W-1:0] alu_func,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero
);

    // Handshake: a request is taken on a cycle where in_valid & in_ready; the result is
    // released on a cycle where out_valid & out_ready. in_ready/out_valid depend on state only.
`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t          state, state_nxt;
    logic [XLEN-1:0] result_nxt;
    logic            zero_nxt;
    logic [XLEN-1:0] calc;

`ifndef ALU_FAST_SHIFT_EN
    logic [XLEN-1:0]  sh_q, sh_nxt, sh_step;
    logic [4:0]       cnt, cnt_nxt;
    logic [ALU_W-1:0] func_q, func_nxt;
    logic             is_shift;

    assign is_shift = (alu_func == 4'd1) || (alu_func == 4'd5) || (alu_func == 4'd13);

    always_comb begin
        case (func_q)
            4'd1:    sh_step = {sh_q[XLEN-2:0], 1'b0};
            4'd5:    sh_step = {1'b0, sh_q[XLEN-1:1]};
            default: sh_step = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
        endcase
    end
`endif

    // Single-cycle result for the request on the input pins; a shift here is either the
    // barrel shifter or, in the iterative build, the zero-amount case (result = a).
    always_comb begin
        case (alu_func)
            4'd0:       calc = op_a + op_b;
            4'd8, 4'd9: calc = op_a - op_b;
            4'd2:       calc = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd3:       calc = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'd4:       calc = op_a ^ op_b;
            4'd6:       calc = op_a | op_b;
            4'd7:       calc = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
            4'd1:       calc = op_a << op_b[4:0];
            4'd5:       calc = op_a >> op_b[4:0];
            4'd13:      calc = $unsigned($signed(op_a) >>> op_b[4:0]);
`else
            4'd1, 4'd5, 4'd13: calc = op_a;
`endif
            default:    calc = '0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        zero_nxt   = zero;
`ifndef ALU_FAST_SHIFT_EN
        sh_nxt     = sh_q;
        cnt_nxt    = cnt;
        func_nxt   = func_q;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift && (op_b[4:0] != 5'd0)) begin
                        sh_nxt    = op_a;
                        cnt_nxt   = op_b[4:0];
                        func_nxt  = alu_func;
                        state_nxt = SHIFT;
                    end else
`endif
                    begin
                        result_nxt = calc;
                        zero_nxt   = (calc == '0);
                        state_nxt  = DONE;
                    end
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            SHIFT: begin
                sh_nxt  = sh_step;
                cnt_nxt = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    result_nxt = sh_step;
                    zero_nxt   = (sh_step == '0);
                    state_nxt  = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            zero   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            sh_q   <= '0;
            cnt    <= '0;
            func_q <= '0;
`endif
        end else begin
            state  <= state_nxt;
            result <= result_nxt;
            zero   <= zero_nxt;
`ifndef ALU_FAST_SHIFT_EN
            sh_q   <= sh_nxt;
            cnt    <= cnt_nxt;
            func_q <= func_nxt;
`endif
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Handshaked execute-stage ALU that consumes the 4-bit `alu_func` code produced by the ALU control decoder, plus two XLEN operands, and returns a registered result and zero flag. Non-shift operations complete in one cycle. Shifts run iteratively, one bit per cycle, unless the fast-shift option is compiled in. It sits between the ALU control/decode stage and the writeback/branch-resolve logic of the core.

## Interface
- `XLEN`, 32: operand/result width.
- `ALU_W`, 4: width of `alu_func`; equals `` `ALU_si `` from def.sv.
- `clk`  in  1: single clock; all state is updated on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operation request.
- `in_ready`  out  1: unit can accept a request; equals (state==IDLE).
- `alu_func`  in  ALU_W: operation code, encoded {sub/arith bit, func3}.
- `op_a`  in  XLEN: first operand.
- `op_b`  in  XLEN: second operand; shift amount is `op_b[4:0]`.
- `out_valid`  out  1: `result` and `zero` are valid.
- `out_ready`  in  1: consumer accepts the result.
- `result`  out  XLEN: registered result.
- `zero`  out  1: registered (result == 0).

## Operation
- Request accept: `in_valid & in_ready` latches `alu_func`, `op_a` and `op_b`.
- Codes and results:
  - 0 ADD: a+b.
  - 8 SUB and 9 branch-compare: a-b.
  - 1 SLL.
  - 2 SLT: signed compare, result 1 or 0.
  - 3 SLTU: unsigned compare, result 1 or 0.
  - 4 XOR.
  - 5 SRL.
  - 13 SRA.
  - 6 OR.
  - 7 AND.
  - 10, 11, 12, 14, 15: result 0, zero=1.
- Add/sub arithmetic is modulo 2^XLEN. Carry is discarded.
- States:
  - IDLE: `in_ready`=1. On accept of a non-shift code, go to DONE. On accept of a shift code with amount 0, go to DONE with result=a. On accept of a shift code with amount>0, load shifter=a and count=amount, then go to SHIFT.
  - SHIFT: each cycle, shift by 1 and decrement count. SLL fills with 0. SRL fills with 0. SRA fills with the sign bit. When the count reaches 0, go to DONE.
  - DONE: `out_valid`=1. `result` and `zero` stay stable until `out_ready`=1, then go to IDLE.
- Requests arriving while not in IDLE are not accepted. The requester holds them.
- Reset mid-operation: the operation in flight is discarded. No output is produced for it.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `zero`=0, internal count=0.
- Non-shift op accepted in cycle N: `out_valid`=1 from cycle N+1.
- Shift by s>0 accepted in cycle N: `out_valid`=1 from cycle N+1+s. Maximum is N+32.
- Output handshake in cycle M (`out_valid` & `out_ready`): `in_ready`=1 in cycle M+1. No accept can happen in the same cycle as the output handshake.
- Peak throughput: one op per 2 cycles.
- `out_ready` held high while `out_valid` is low has no effect.
- `in_ready` depends only on state, never combinationally on `in_valid` or `out_ready`.

## Configuration
- `ALU_FAST_SHIFT_EN` defined:
  - Shifts use a single-cycle barrel shifter. IDLE goes directly to DONE for all codes.
  - SHIFT state and counter are not built.
  - All ops have `out_valid` at N+1.
- `ALU_FAST_SHIFT_EN` undefined: iterative shifter as described above.
- Both builds give bit-identical `result` and `zero`. Only latency differs.

## Test plan
- Reset, then ADD: hold `rst_n`=0 and check `in_ready`=1, `out_valid`=0, `result`=0. Release, then send ADD a=0x7FFFFFFF, b=1. Expect `out_valid` at N+1, result=0x80000000, zero=0.
- SUB and compares:
  - SUB (code 8) a=5, b=5: result=0, zero=1.
  - Code 9 a=3, b=7: result=0xFFFFFFFC.
  - SLT a=0xFFFFFFFF, b=1: result 1.
  - SLTU with the same operands: result 0.
- Iterative shifts:
  - SRA a=0x80000000, b=31: result=0xFFFFFFFF, `out_valid` at N+32.
  - SLL a=1, b=0: result=1 at N+1.
  - SRL a=0xF0, b=4: result=0xF at N+5.
- Backpressure: `out_ready`=0 for 10 cycles after AND a=0xFF00, b=0x0FF0. Result 0x0F00 stays stable, `in_ready`=0 throughout, and a pending `in_valid` is not accepted. Release `out_ready`; `in_ready` rises the next cycle.
- Reset mid-shift: start SLL b=20, pulse `rst_n` low at cycle N+5. Expect `out_valid`=0, `result`=0, `in_ready`=1 immediately. No stale output afterwards.
- Illegal code 12 a=9, b=9: result=0, zero=1.
- Repeat the shift cases with `ALU_FAST_SHIFT_EN` defined: identical values, all at N+1.
